hwpe_ctrl_ctx_scheduler: RTL and testbench
==========================================

Name: hwpe_ctrl_ctx_scheduler

Overview:
Job-context scheduler for the HWPE control register file. It arbitrates the offload lock between cores (test-and-set acquire, trigger release), tracks which job contexts are occupied, and sequences the engine through queued jobs in FIFO order. It generates the pointer/running context indices and the full, critical and true_done flags that the register file consumes.

Parameters:
N_CONTEXT, 2, number of job contexts (1..4, non-power-of-2 allowed)
ID_WIDTH, 16, width of requester (core) id

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
clear_i  in  1  synchronous soft clear, same effect as reset
testset_i  in  1  acquire attempt (test-and-set read), 1-cycle pulse
testset_src_i  in  ID_WIDTH  requester id of the acquire
trigger_i  in  1  commit job in pointer context, 1-cycle pulse
trigger_src_i  in  ID_WIDTH  requester id of the trigger
done_i  in  1  engine finished current job, 1-cycle pulse
start_o  out  1  start engine on running context, 1-cycle pulse
busy_o  out  1  any context occupied or engine not IDLE
pointer_context_o  out  CW=max(1,$clog2(N_CONTEXT))  context being programmed
running_context_o  out  CW  context executing / next to execute
full_context_o  out  1  all contexts occupied
is_critical_o  out  1  offload lock held
true_done_o  out  1  job retired, 1-cycle pulse
evt_o  out  1  completion event, equal to true_done_o
trigger_err_o  out  1  rejected trigger, 1-cycle pulse

Behaviour:
- Reset/clear (rst_ni low or clear_i high at clk edge): all state and outputs 0; FSM = IDLE; lock free; occupied count 0; both pointers 0.
- All flag outputs are registered state, readable combinationally in the same cycle as testset_i so the register file computes its test-and-set response from them.
- Acquire: testset_i & ~is_critical & ~full -> next cycle is_critical=1, owner<=testset_src_i. If lock is held or full: no state change (register file returns -2 / -1).
- Trigger: trigger_i & is_critical & trigger_src_i==owner -> valid[pointer]<=1, occupied+1, pointer wraps N_CONTEXT-1 -> 0, is_critical<=0.
- Trigger without lock, or from non-owner -> ignored; trigger_err_o pulses next cycle.
- full_context_o = (occupied==N_CONTEXT). Occupied counter width $clog2(N_CONTEXT+1); never over/underflows.
- Engine FSM, states IDLE, START, RUN, RETIRE:
  - IDLE: if valid[running] -> START.
  - START: start_o=1 for exactly one cycle -> RUN.
  - RUN: wait for done_i -> RETIRE.
  - RETIRE: true_done_o=evt_o=1 for one cycle; valid[running]<=0, occupied-1, running wraps -> IDLE.
- Latency: trigger_i in cycle n on idle engine -> start_o in cycle n+2; done_i in cycle m -> true_done_o in cycle m+1; next queued start_o in cycle m+3.
- done_i outside RUN: ignored.
- Trigger and RETIRE in the same cycle: occupied unchanged, both valid-bit updates applied (different indices, guaranteed by the full check).
- Acquire while full but RETIRE is in progress: evaluated on the current (full) flag, so it is rejected.
- busy_o = (occupied!=0) | (state!=IDLE).
- Reset/clear mid-RUN: FSM returns to IDLE and no true_done_o is issued; a later done_i is ignored.

Decomposition:
- hwpe_ctrl_package: add enum ctx_sched_state_t {IDLE, START, RUN, RETIRE}. Reuse REGFILE_N_CONTEXT as the N_CONTEXT default.
- Flat module; no sub-module. Its flag outputs map 1:1 onto flags_regfile_t fields (is_critical, full_context, pointer_context, running_context, true_done), packed by the parent slave.

Test Plan:
- Reset then core 3 testset, trigger(src 3) -> is_critical 1 then 0; pointer_context 0->1; start_o at n+2; done_i -> true_done_o one cycle later; running_context 0->1; busy_o 0.
- Core 1 holds lock, core 2 testset and trigger -> no lock change; trigger_err_o=1 once; valid bits unchanged.
- N_CONTEXT=2: two acquire/trigger jobs while engine in RUN -> full_context_o=1; third testset rejected; after first retire full_context_o=0 and start_o for context 1 at m+3.
- Trigger in the same cycle as RETIRE with occupied=1 -> occupied stays 1; pointer and running both advance; no glitch on full_context_o.
- N_CONTEXT=3: run 4 jobs back-to-back -> pointer and running wrap 2->0; true_done_o count = 4.
- clear_i asserted during RUN, then done_i -> all outputs 0; no true_done_o; subsequent job starts from context 0.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared types and constants for the HWPE control block.
// Holds the context scheduler state encoding and the register-file context count.
package hwpe_ctrl_package;

    localparam int unsigned REGFILE_N_CONTEXT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        RETIRE = 2'd3
    } ctx_sched_state_t;

    // Circular successor of a context index; n need not be a power of two.
    function automatic int unsigned ctx_wrap(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_ctx_scheduler.sv
// Job-context scheduler: offload lock, context occupancy and FIFO engine sequencing.
// Trigger to start_o in 2 cycles on an idle engine; done_i to true_done_o in 1 cycle.
module hwpe_ctrl_ctx_scheduler
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CONTEXT = REGFILE_N_CONTEXT,
    parameter int unsigned ID_WIDTH  = 16,
    localparam int unsigned CW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                testset_i,
    input  logic [ID_WIDTH-1:0] testset_src_i,
    input  logic                trigger_i,
    input  logic [ID_WIDTH-1:0] trigger_src_i,
    input  logic                done_i,
    output logic                start_o,
    output logic                busy_o,
    output logic [CW-1:0]       pointer_context_o,
    output logic [CW-1:0]       running_context_o,
    output logic                full_context_o,
    output logic                is_critical_o,
    output logic                true_done_o,
    output logic                evt_o,
    output logic                trigger_err_o
);

    localparam int unsigned OW = $clog2(N_CONTEXT + 1);

    ctx_sched_state_t      r_state;
    logic [N_CONTEXT-1:0]  r_valid;
    logic [OW-1:0]         r_occ;
    logic [CW-1:0]         r_ptr;
    logic [CW-1:0]         r_run;
    logic                  r_crit;
    logic [ID_WIDTH-1:0]   r_owner;
    logic                  r_start;
    logic                  r_true_done;
    logic                  r_trig_err;

    logic                  w_full;
    logic                  w_acq_ok;
    logic                  w_trig_ok;
    logic                  w_retire;
    logic [CW-1:0]         w_ptr_nxt;
    logic [CW-1:0]         w_run_nxt;

    assign w_full    = (r_occ == OW'(N_CONTEXT));
    assign w_acq_ok  = testset_i & ~r_crit & ~w_full;
    assign w_trig_ok = trigger_i & r_crit & (trigger_src_i == r_owner);
    assign w_retire  = (r_state == RETIRE);
    assign w_ptr_nxt = CW'(ctx_wrap(32'(r_ptr), N_CONTEXT));
    assign w_run_nxt = CW'(ctx_wrap(32'(r_run), N_CONTEXT));

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_occ       <= '0;
            r_ptr       <= '0;
            r_run       <= '0;
            r_crit      <= 1'b0;
            r_owner     <= '0;
            r_start     <= 1'b0;
            r_true_done <= 1'b0;
            r_trig_err  <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_true_done <= 1'b0;
            r_trig_err  <= trigger_i & ~w_trig_ok;

            if (w_acq_ok) begin
                r_crit  <= 1'b1;
                r_owner <= testset_src_i;
            end
            if (w_trig_ok) begin
                r_valid[r_ptr] <= 1'b1;
                r_ptr          <= w_ptr_nxt;
                r_crit         <= 1'b0;
            end

            // A commit and a retire in the same cycle cancel out on the count.
            if (w_trig_ok && !w_retire) begin
                r_occ <= r_occ + OW'(1);
            end else if (!w_trig_ok && w_retire) begin
                r_occ <= r_occ - OW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (r_valid[r_run]) begin
                        r_state <= START;
                        r_start <= 1'b1;
                    end
                end
                START: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (done_i) begin
                        r_state     <= RETIRE;
                        r_true_done <= 1'b1;
                    end
                end
                RETIRE: begin
                    r_valid[r_run] <= 1'b0;
                    r_run          <= w_run_nxt;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_o           = r_start;
    assign busy_o            = (r_occ != '0) | (r_state != IDLE);
    assign pointer_context_o = r_ptr;
    assign running_context_o = r_run;
    assign full_context_o    = w_full;
    assign is_critical_o     = r_crit;
    assign true_done_o       = r_true_done;
    assign evt_o             = r_true_done;
    assign trigger_err_o     = r_trig_err;

endmodule

// File: tb/tb_hwpe_ctrl_ctx_scheduler.sv
// Two schedulers (2 and 3 contexts) share one stimulus stream and are compared each
// cycle against a timestamp-based job model, plus hand-computed spot values.
module tb_hwpe_ctrl_ctx_scheduler;

    logic        clk = 1'b0;
    logic        rst_ni, clear_i, testset_i, trigger_i, done_i;
    logic [15:0] testset_src_i, trigger_src_i;

    logic       o0_start, o0_busy, o0_full, o0_crit, o0_td, o0_evt, o0_err;
    logic [0:0] o0_ptr, o0_run;
    logic       o1_start, o1_busy, o1_full, o1_crit, o1_td, o1_evt, o1_err;
    logic [1:0] o1_ptr, o1_run;

    always #5 clk = ~clk;

    hwpe_ctrl_ctx_scheduler #(.N_CONTEXT(2), .ID_WIDTH(16)) u0 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .testset_i(testset_i), .testset_src_i(testset_src_i),
        .trigger_i(trigger_i), .trigger_src_i(trigger_src_i), .done_i(done_i),
        .start_o(o0_start), .busy_o(o0_busy), .pointer_context_o(o0_ptr),
        .running_context_o(o0_run), .full_context_o(o0_full), .is_critical_o(o0_crit),
        .true_done_o(o0_td), .evt_o(o0_evt), .trigger_err_o(o0_err));

    hwpe_ctrl_ctx_scheduler #(.N_CONTEXT(3), .ID_WIDTH(16)) u1 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .testset_i(testset_i), .testset_src_i(testset_src_i),
        .trigger_i(trigger_i), .trigger_src_i(trigger_src_i), .done_i(done_i),
        .start_o(o1_start), .busy_o(o1_busy), .pointer_context_o(o1_ptr),
        .running_context_o(o1_run), .full_context_o(o1_full), .is_critical_o(o1_crit),
        .true_done_o(o1_td), .evt_o(o1_evt), .trigger_err_o(o1_err));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int td1 = 0;

    // Job model: lock owner, context ring, and per-job timestamps.
    int mN[2] = '{2, 3};
    int mcrit[2], mowner[2], mptr[2], mrun[2], mocc[2];
    int mhs[2], mhd[2], mfree[2], merr[2];
    int mvis[2][4];

    task automatic cmp(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int k);
        int  old;
        bit  trig_ok, acq_ok;
        old = cyc;
        if (!rst_ni || clear_i) begin
            mcrit[k] = 0; mowner[k] = 0; mptr[k] = 0; mrun[k] = 0; mocc[k] = 0;
            mhs[k] = -1; mhd[k] = -1; mfree[k] = old + 1; merr[k] = 0;
            return;
        end
        trig_ok = trigger_i && (mcrit[k] != 0) && (int'(trigger_src_i) == mowner[k]);
        acq_ok  = testset_i && (mcrit[k] == 0) && (mocc[k] != mN[k]);
        merr[k] = (trigger_i && !trig_ok) ? 1 : 0;
        // done counts only once the head job has started and is not yet finished
        if (mhs[k] >= 0 && old > mhs[k] && mhd[k] < 0 && done_i) mhd[k] = old;
        if (mhd[k] >= 0 && old == mhd[k] + 1) begin
            mocc[k]--;
            mrun[k]  = (mrun[k] + 1) % mN[k];
            mfree[k] = old + 1;
            mhs[k]   = -1;
            mhd[k]   = -1;
        end
        if (acq_ok) begin
            mcrit[k]  = 1;
            mowner[k] = int'(testset_src_i);
        end
        if (trig_ok) begin
            mvis[k][mptr[k]] = old + 1;
            mocc[k]++;
            mptr[k]  = (mptr[k] + 1) % mN[k];
            mcrit[k] = 0;
        end
        if (mhs[k] < 0 && mocc[k] > 0)
            mhs[k] = ((mvis[k][mrun[k]] > mfree[k]) ? mvis[k][mrun[k]] : mfree[k]) + 1;
    endtask

    task automatic check_inst(input int k, input int st, input int td, input int ev,
                              input int bz, input int fl, input int cr, input int pt,
                              input int rn, input int er);
        string p;
        int    etd;
        p   = (k == 0) ? "n2" : "n3";
        etd = (mhd[k] >= 0 && cyc == mhd[k] + 1) ? 1 : 0;
        cmp({p, ".start_o"}, st, (mhs[k] == cyc) ? 1 : 0);
        cmp({p, ".true_done_o"}, td, etd);
        cmp({p, ".evt_o"}, ev, etd);
        cmp({p, ".busy_o"}, bz, (mocc[k] != 0) ? 1 : 0);
        cmp({p, ".full_context_o"}, fl, (mocc[k] == mN[k]) ? 1 : 0);
        cmp({p, ".is_critical_o"}, cr, mcrit[k]);
        cmp({p, ".pointer_context_o"}, pt, mptr[k]);
        cmp({p, ".running_context_o"}, rn, mrun[k]);
        cmp({p, ".trigger_err_o"}, er, merr[k]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step(0);
            model_step(1);
            cyc++;
            check_inst(0, o0_start, o0_td, o0_evt, o0_busy, o0_full, o0_crit,
                       int'(o0_ptr), int'(o0_run), o0_err);
            check_inst(1, o1_start, o1_td, o1_evt, o1_busy, o1_full, o1_crit,
                       int'(o1_ptr), int'(o1_run), o1_err);
            if (o1_td) td1++;
        end
    end

    task automatic drive(input logic ts, input int tss, input logic tr, input int trs,
                         input logic dn, input logic clr);
        @(negedge clk);
        testset_i     = ts;
        testset_src_i = 16'(tss);
        trigger_i     = tr;
        trigger_src_i = 16'(trs);
        done_i        = dn;
        clear_i       = clr;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (o0_start) begin
                s = cyc;
                break;
            end
        end
        cmp("start_seen", (s >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        int tn, s, m, snap;
        rst_ni = 1'b0; clear_i = 1'b0; testset_i = 1'b0; trigger_i = 1'b0; done_i = 1'b0;
        testset_src_i = '0; trigger_src_i = '0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        cmp("rst.pointer", int'(o0_ptr), 0);
        cmp("rst.busy", o0_busy, 0);
        cmp("rst.crit", o0_crit, 0);

        // Single job from core 3
        drive(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 3, 1'b0, 1'b0);
        cmp("s1.crit_held", o0_crit, 1);
        tn = cyc;
        idle();
        cmp("s1.crit_released", o0_crit, 0);
        cmp("s1.pointer", int'(o0_ptr), 1);
        wait_start(s);
        cmp("s1.start_latency", s, tn + 2);
        idle();
        drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        idle();
        cmp("s1.true_done", o0_td, 1);
        idle();
        cmp("s1.running", int'(o0_run), 1);
        cmp("s1.busy", o0_busy, 0);

        // Lock held by core 1; core 2 is rejected
        drive(1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
        idle();
        cmp("s2.trigger_err", o0_err, 1);
        cmp("s2.owner_kept", o0_crit, 1);
        cmp("s2.pointer_kept", int'(o0_ptr), 1);
        idle();
        cmp("s2.err_once", o0_err, 0);
        drive(1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
        idle();
        wait_start(s);
        idle();
        drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        idle(); idle();

        // Fill two contexts while the engine runs
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        idle();
        drive(1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
        idle();
        wait_start(s);
        drive(1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
        idle();
        cmp("s3.n2_full", o0_full, 1);
        cmp("s3.n3_not_full", o1_full, 0);
        drive(1'b1, 4, 1'b0, 0, 1'b0, 1'b0);
        idle();
        cmp("s3.n2_acq_rejected", o0_crit, 0);
        cmp("s3.n3_acq_taken", o1_crit, 1);
        drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        m = cyc;
        idle();
        cmp("s3.true_done", o0_td, 1);
        wait_start(s);
        cmp("s3.next_start", s, m + 3);
        cmp("s3.full_cleared", o0_full, 0);
        cmp("s3.running_ctx1", int'(o0_run), 1);
        drive(1'b0, 0, 1'b1, 4, 1'b0, 1'b0);
        idle();
        cmp("s3.n2_err", o0_err, 1);
        cmp("s3.n3_no_err", o1_err, 0);

        // Commit in the same cycle as a retire
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        idle();
        drive(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 5, 1'b0, 1'b0);
        idle();
        wait_start(s);
        drive(1'b1, 6, 1'b0, 0, 1'b0, 1'b0);
        idle();
        drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 6, 1'b0, 1'b0);
        idle();
        cmp("s4.busy", o0_busy, 1);
        cmp("s4.full", o0_full, 0);
        cmp("s4.n2_pointer", int'(o0_ptr), 0);
        cmp("s4.n3_pointer", int'(o1_ptr), 2);
        cmp("s4.running", int'(o0_run), 1);

        // Four jobs in sequence: ring wrap
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        idle();
        snap = td1;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 10 + j, 1'b0, 0, 1'b0, 1'b0);
            drive(1'b0, 0, 1'b1, 10 + j, 1'b0, 1'b0);
            idle();
            wait_start(s);
            idle();
            drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
            idle(); idle();
        end
        cmp("s5.true_done_count", td1 - snap, 4);
        cmp("s5.n3_pointer", int'(o1_ptr), 1);
        cmp("s5.n3_running", int'(o1_run), 1);
        cmp("s5.n2_pointer", int'(o0_ptr), 0);

        // Clear while running, then a stale done
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        idle();
        snap = td1;
        drive(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 7, 1'b0, 1'b0);
        idle();
        wait_start(s);
        idle();
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        idle();
        cmp("s6.busy_cleared", o0_busy, 0);
        drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        idle(); idle();
        cmp("s6.no_true_done", td1 - snap, 0);
        cmp("s6.pointer_zero", int'(o0_ptr), 0);
        drive(1'b1, 8, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 8, 1'b0, 1'b0);
        idle();
        cmp("s6.pointer_one", int'(o0_ptr), 1);
        wait_start(s);
        cmp("s6.running_zero", int'(o0_run), 0);
        idle();
        drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        repeat (4) idle();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
